jump_target_unit: RTL and testbench

Computes the absolute jump target for MIPS-style J/JAL (pseudo-direct) and JR (register) jumps in the single-cycle/pipelined CPU PC path. It provides the target combinationally for same-cycle PC selection. It also captures the target in a register with a valid flag and a misalignment flag for downstream PC/exception logic.

---
 rtl/jump_target_unit.sv | 64 ++++++
 tb/tb_jump_target_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/jump_target_unit.sv
// Jump target unit: forms J/JAL pseudo-direct or JR register targets combinationally,
// and registers the target with valid and misalignment flags for the PC/exception path.
module jump_target_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] JIm,
    input  logic [3:0]  PCHead,
    input  logic [31:0] RegPC,
    input  logic        JType,
    input  logic        JValid,
    output logic [31:0] JumpPCNext,
    output logic [31:0] JumpPC,
    output logic        JumpValid,
    output logic        AlignErr
);

    function automatic logic [31:0] pseudo_direct(input logic [3:0] head,
                                                   input logic [25:0] index);
        return {head, index, 2'b00};
    endfunction

    function automatic logic word_misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

    logic [31:0] target_p0;
    logic        align_err_p0;

    logic [31:0] jump_pc_p1;
    logic        vld_p1;
    logic        align_err_p1;

    // Stage p0: combinational target selection, no arithmetic involved
    always_comb begin
        target_p0    = pseudo_direct(PCHead, JIm);
        align_err_p0 = 1'b0;
        if (JType) begin
            target_p0    = RegPC;
            align_err_p0 = word_misaligned(RegPC);
        end
    end

    assign JumpPCNext = target_p0;

    // Stage p1: target holds when no jump is requested; flags are per-edge pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_pc_p1   <= 32'h0000_0000;
            vld_p1       <= 1'b0;
            align_err_p1 <= 1'b0;
        end else begin
            vld_p1       <= JValid;
            align_err_p1 <= JValid & align_err_p0;
            if (JValid) begin
                jump_pc_p1 <= target_p0;
            end
        end
    end

    assign JumpPC    = jump_pc_p1;
    assign JumpValid = vld_p1;
    assign AlignErr  = align_err_p1;

endmodule

// File: tb/tb_jump_target_unit.sv
// Randomized bench for jump_target_unit against an arithmetic reference model,
// plus literal expectations for the documented scenarios.
module tb_jump_target_unit;

    logic        clk;
    logic        reset;
    logic [25:0] jim;
    logic [15:0] pchead_w;
    logic [31:0] regpc;
    logic        jtype;
    logic        jvalid;
    logic [31:0] jump_pc_next;
    logic [31:0] jump_pc;
    logic        jump_valid;
    logic        align_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference state: what the registered outputs must hold
    logic [31:0] m_pc;
    logic        m_vld;
    logic        m_err;

    jump_target_unit dut (
        .clk        (clk),
        .reset      (reset),
        .JIm        (jim),
        .PCHead     (pchead_w[3:0]),
        .RegPC      (regpc),
        .JType      (jtype),
        .JValid     (jvalid),
        .JumpPCNext (jump_pc_next),
        .JumpPC     (jump_pc),
        .JumpValid  (jump_valid),
        .AlignErr   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_target(input logic [25:0] index,
                                                 input logic [15:0] head_w,
                                                 input logic [31:0] rpc,
                                                 input logic        t);
        longint unsigned v;
        if (t) return rpc;
        v = longint'(index) * 4 + longint'(head_w % 16) * 64'd268435456;
        return v[31:0];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc  = 32'h0;
            m_vld = 1'b0;
            m_err = 1'b0;
        end else if (jvalid) begin
            m_pc  = model_target(jim, pchead_w, regpc, jtype);
            m_vld = 1'b1;
            m_err = jtype && (regpc % 4 != 0);
        end else begin
            m_vld = 1'b0;
            m_err = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("cmp_next", jump_pc_next, model_target(jim, pchead_w, regpc, jtype));
            chk("cmp_pc", jump_pc, m_pc);
            chk("cmp_vld", {31'b0, jump_valid}, {31'b0, m_vld});
            chk("cmp_err", {31'b0, align_err}, {31'b0, m_err});
        end
    end

    task automatic drive(input logic [25:0] j, input logic [15:0] h, input logic [31:0] r,
                         input logic t, input logic v);
        @(negedge clk);
        #2;
        jim      = j;
        pchead_w = h;
        regpc    = r;
        jtype    = t;
        jvalid   = v;
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        jim      = '0;
        pchead_w = '0;
        regpc    = '0;
        jtype    = 1'b0;
        jvalid   = 1'b0;
        #3;
        chk("rst_pc", jump_pc, 32'h0);
        chk("rst_vld", {31'b0, jump_valid}, 32'h0);
        chk("rst_err", {31'b0, align_err}, 32'h0);
        @(negedge clk);
        #2;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Pseudo-direct example
        drive(26'b11000011101001011000000111, 16'h000d, 32'h0, 1'b0, 1'b1);
        #1;
        chk("pd_next", jump_pc_next, 32'hDC3A581C);
        after_edge();
        chk("pd_pc", jump_pc, 32'hDC3A581C);
        chk("pd_vld", {31'b0, jump_valid}, 32'h1);
        chk("pd_err", {31'b0, align_err}, 32'h0);

        // Zero and all-ones boundaries
        drive(26'h0, 16'h0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        #1;
        chk("zero_next", jump_pc_next, 32'h0000_0000);
        drive(26'h3FFFFFF, 16'h000F, 32'h0, 1'b0, 1'b1);
        #1;
        chk("ones_next", jump_pc_next, 32'hFFFF_FFFC);
        after_edge();
        chk("ones_pc", jump_pc, 32'hFFFF_FFFC);

        // Register jumps, aligned then misaligned
        drive(26'h155, 16'h3, 32'h0040_3008, 1'b1, 1'b1);
        after_edge();
        chk("jr_pc", jump_pc, 32'h0040_3008);
        chk("jr_err", {31'b0, align_err}, 32'h0);
        drive(26'h155, 16'h3, 32'h0040_3006, 1'b1, 1'b1);
        after_edge();
        chk("jr_mis_pc", jump_pc, 32'h0040_3006);
        chk("jr_mis_err", {31'b0, align_err}, 32'h1);
        chk("jr_mis_vld", {31'b0, jump_valid}, 32'h1);

        // Hold
        drive(26'h0, 16'h0, 32'h1234_5678, 1'b1, 1'b1);
        after_edge();
        drive(26'h2AAAAAA, 16'h0007, 32'h0BAD_F00D, 1'b0, 1'b0);
        #1;
        chk("hold_next", jump_pc_next, 32'h7AAA_AAA8);
        after_edge();
        chk("hold_pc", jump_pc, 32'h1234_5678);
        chk("hold_vld", {31'b0, jump_valid}, 32'h0);
        chk("hold_err", {31'b0, align_err}, 32'h0);

        // Truncation of a wide PC head
        drive(26'h0, 16'habcd, 32'h0, 1'b0, 1'b0);
        #1;
        chk("trunc_next", jump_pc_next, 32'hD000_0000);

        // Asynchronous reset mid-cycle with a nonzero misaligned target loaded
        drive(26'h0, 16'h0, 32'h8765_4323, 1'b1, 1'b1);
        after_edge();
        chk("pre_rst_pc", jump_pc, 32'h8765_4323);
        reset = 1'b1;
        #1;
        chk("arst_pc", jump_pc, 32'h0);
        chk("arst_vld", {31'b0, jump_valid}, 32'h0);
        chk("arst_err", {31'b0, align_err}, 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Randomized traffic, including runs of back-to-back jumps
        for (int i = 0; i < 400; i++) begin
            drive(26'($urandom), 16'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 3) != 0));
            if (i == 200) begin
                #1;
                reset = 1'b1;
                #1;
                chk("rnd_arst_pc", jump_pc, 32'h0);
                @(negedge clk);
                #1;
                reset = 1'b0;
            end
        end
        after_edge();
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
